// File: rtl/irq_controller_if.sv
// irq_controller_if
// Bundles every irq_controller signal except clock and reset.
//   irq_in     : external request lines, already synchronous to clk
//   cfg_*      : register window (MASK / PENDING / STATUS / reserved)
//   int_ack    : core accepts the presented interrupt (1-cycle pulse)
//   int_done   : core executed return-from-interrupt (1-cycle pulse)
//   interrupt  : request to the core
//   int_id     : selected source index
//   int_vector : handler address of the selected source
// The "slave" modport is the controller; "master" is the side that drives
// the requests and the configuration port (core / software / bench).
interface irq_controller_if;
    logic [3:0]  irq_in;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        int_ack;
    logic        int_done;
    logic        interrupt;
    logic [1:0]  int_id;
    logic [15:0] int_vector;

    modport slave (
        input  irq_in, cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
        output cfg_rdata, interrupt, int_id, int_vector
    );

    modport master (
        output irq_in, cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
        input  cfg_rdata, interrupt, int_id, int_vector
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
// Prioritised four-source interrupt controller feeding the core's interrupt
// input. Rising edges on irq_in set pending latches; the lowest-index source
// in (pending & mask) is presented with its handler vector, then the
// ack / return-from-interrupt handshake is tracked.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : irq_controller_if.slave (requests, config window, core handshake)
module irq_controller #(
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
    input  logic               clk,
    input  logic               reset,
    irq_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  irq_prev_q;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  pending_q, pending_d;
    logic        interrupt_q, interrupt_d;
    logic [1:0]  int_id_q, int_id_d;
    logic [15:0] int_vector_q, int_vector_d;

    logic [3:0]  edge_s;
    logic [3:0]  cand_s;
    logic [3:0]  w1c_s;
    logic [3:0]  ack_clr_s;
    logic [3:0]  id_onehot_s;
    logic [1:0]  winner_s;
    logic [15:0] status_s;
    logic        unused_wdata_s;

    // Fixed priority: lowest index wins.
    function automatic logic [1:0] pick_winner(input logic [3:0] cand);
        logic [1:0] w;
        if (cand[0]) begin
            w = 2'd0;
        end else if (cand[1]) begin
            w = 2'd1;
        end else if (cand[2]) begin
            w = 2'd2;
        end else begin
            w = 2'd3;
        end
        return w;
    endfunction

    // Handler address; 16-bit arithmetic wraps modulo 2^16.
    function automatic logic [15:0] vector_of(input logic [1:0] id);
        return VEC_BASE + ({14'd0, id} * VEC_STRIDE);
    endfunction

    assign unused_wdata_s = &{1'b0, bus.cfg_wdata[15:4]};

    // Edge detection, candidate set, register-write decode.
    always_comb begin
        edge_s      = bus.irq_in & ~irq_prev_q;
        cand_s      = pending_q & mask_q;
        winner_s    = pick_winner(cand_s);
        id_onehot_s = 4'b0001 << int_id_q;
        if (bus.cfg_we && (bus.cfg_addr == 2'd0)) begin
            mask_d = bus.cfg_wdata[3:0];
        end else begin
            mask_d = mask_q;
        end
        if (bus.cfg_we && (bus.cfg_addr == 2'd1)) begin
            w1c_s = bus.cfg_wdata[3:0];
        end else begin
            w1c_s = 4'b0000;
        end
    end

    // FSM next state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        interrupt_d  = interrupt_q;
        int_id_d     = int_id_q;
        int_vector_d = int_vector_q;
        ack_clr_s    = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (cand_s != 4'b0000) begin
                    state_d      = ST_REQ;
                    interrupt_d  = 1'b1;
                    int_id_d     = winner_s;
                    int_vector_d = vector_of(winner_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    ack_clr_s   = id_onehot_s;
                    state_d     = ST_SERVICE;
                    interrupt_d = 1'b0;
                end else if ((pending_q[int_id_q] & mask_q[int_id_q]) == 1'b0) begin
                    // Source withdrawn by software (W1C or mask) before ack.
                    state_d     = ST_IDLE;
                    interrupt_d = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (bus.int_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                interrupt_d = 1'b0;
            end
        endcase
        // A new edge outranks both the W1C clear and the ack clear.
        pending_d = (pending_q & ~w1c_s & ~ack_clr_s) | edge_s;
    end

    // State and register updates with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_prev_q   <= 4'b1111;
            mask_q       <= 4'b0000;
            pending_q    <= 4'b0000;
            interrupt_q  <= 1'b0;
            int_id_q     <= 2'd0;
            int_vector_q <= VEC_BASE;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= bus.irq_in;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            interrupt_q  <= interrupt_d;
            int_id_q     <= int_id_d;
            int_vector_q <= int_vector_d;
        end
    end

    // Combinational register read window.
    always_comb begin
        status_s = {12'h000, (state_q == ST_SERVICE), (state_q == ST_REQ), int_id_q};
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = {12'h000, mask_q};
            2'd1:    bus.cfg_rdata = {12'h000, pending_q};
            2'd2:    bus.cfg_rdata = status_s;
            default: bus.cfg_rdata = 16'h0000;
        endcase
    end

    assign bus.interrupt  = interrupt_q;
    assign bus.int_id     = int_id_q;
    assign bus.int_vector = int_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller with default vector
// parameters (base 16'h0040, stride 16'h0004). Each table row is one clock:
// inputs are driven at the falling edge and outputs are compared 1 ns after
// the following rising edge.
module tb_irq_controller;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    irq_controller_if bus ();

    irq_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        ack;
        logic        done;
        logic        e_int;
        logic [1:0]  e_id;
        logic [15:0] e_vec;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] irq, input logic we, input logic [1:0] addr,
                        input logic [15:0] wd, input logic ack, input logic done);
        @(negedge clk);
        bus.irq_in    = irq;
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
        bus.int_ack   = ack;
        bus.int_done  = done;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic e_int, input logic [1:0] e_id,
                           input logic [15:0] e_vec);
        chk({nm, ".interrupt"}, {15'd0, bus.interrupt}, {15'd0, e_int});
        chk({nm, ".int_id"}, {14'd0, bus.int_id}, {14'd0, e_id});
        chk({nm, ".int_vector"}, bus.int_vector, e_vec);
    endtask

    // Changes only the read address (no clock) and checks the read data.
    task automatic rd(input string nm, input logic [1:0] addr, input logic [15:0] exp);
        bus.cfg_addr = addr;
        bus.cfg_we   = 1'b0;
        #1;
        chk(nm, bus.cfg_rdata, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.irq_in = 4'h0; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0;
        bus.cfg_wdata = 16'h0000; bus.int_ack = 1'b0; bus.int_done = 1'b0;
        reset = 1'b1;

        //                irq   we    ad    wdata     ack   done  int   id    vec       rdata
        // basic handshake on source 2
        vecs.push_back('{4'h0, 1'b1, 2'd0, 16'h000F, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0040, 16'h000F});
        vecs.push_back('{4'h0, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0040, 16'h0000});
        vecs.push_back('{4'h4, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0040, 16'h0004});
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0048, 16'h0006});
        vecs.push_back('{4'h0, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0048, 16'h0000});
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0048, 16'h000A});
        // state bits clear; int_id field keeps the last served source
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2, 16'h0048, 16'h0002});
        // priority: sources 3 and 1 together
        vecs.push_back('{4'hA, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0048, 16'h000A});
        vecs.push_back('{4'hA, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0044, 16'h0005});
        vecs.push_back('{4'hA, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0044, 16'h0008});
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0044, 16'h0001});
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd3, 16'h004C, 16'h0007});
        vecs.push_back('{4'h0, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd3, 16'h004C, 16'h0000});
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd3, 16'h004C, 16'h0003});
        // masking: pending while disabled, then enable
        vecs.push_back('{4'h0, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'h004C, 16'h0000});
        vecs.push_back('{4'h1, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'h004C, 16'h0001});
        vecs.push_back('{4'h0, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'h004C, 16'h0001});
        vecs.push_back('{4'h0, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'h004C, 16'h0001});
        vecs.push_back('{4'h0, 1'b1, 2'd0, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd3, 16'h004C, 16'h0001});
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0040, 16'h0004});
        // stray int_done while in REQ
        vecs.push_back('{4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0040, 16'h0004});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 2'd0, 16'h0040);
        rd("reset.mask", 2'd0, 16'h0000);
        rd("reset.pending", 2'd1, 16'h0000);
        rd("reset.status", 2'd2, 16'h0000);
        rd("reset.reserved", 2'd3, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].irq, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].done);
            chk_out($sformatf("vec%0d", i), vecs[i].e_int, vecs[i].e_id, vecs[i].e_vec);
            chk($sformatf("vec%0d.rdata", i), bus.cfg_rdata, vecs[i].e_rdata);
        end

        // withdraw: W1C of the requested source while in REQ
        step(4'h0, 1'b1, 2'd1, 16'h0001, 1'b0, 1'b0);
        step(4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0);
        chk("withdraw.interrupt", {15'd0, bus.interrupt}, 16'h0000);
        chk("withdraw.status", bus.cfg_rdata, 16'h0000);
        rd("withdraw.pending", 2'd1, 16'h0000);

        // stray int_ack while IDLE; reserved address write ignored
        step(4'h0, 1'b1, 2'd3, 16'hFFFF, 1'b1, 1'b0);
        chk("stray_ack.interrupt", {15'd0, bus.interrupt}, 16'h0000);
        rd("stray_ack.status", 2'd2, 16'h0000);
        rd("stray_ack.mask", 2'd0, 16'h0001);

        // W1C racing a new edge on the same bit
        step(4'h1, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0);
        step(4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0);
        chk_out("race_req", 1'b1, 2'd0, 16'h0040);
        step(4'h1, 1'b1, 2'd1, 16'h0001, 1'b0, 1'b0);
        chk("race_w1c.pending", bus.cfg_rdata, 16'h0001);
        step(4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0);
        chk("race_w1c.interrupt", {15'd0, bus.interrupt}, 16'h0001);
        chk("race_w1c.status", bus.cfg_rdata, 16'h0004);

        // ack racing a new edge: bit stays pending and is re-requested
        step(4'h1, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0);
        chk("race_ack.pending", bus.cfg_rdata, 16'h0001);
        chk("race_ack.interrupt", {15'd0, bus.interrupt}, 16'h0000);
        step(4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1);
        chk("race_ack.done_status", bus.cfg_rdata, 16'h0000);
        step(4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0);
        chk("race_ack.rerequest", {15'd0, bus.interrupt}, 16'h0001);
        step(4'h0, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0);
        chk("race_ack.cleared", bus.cfg_rdata, 16'h0000);
        step(4'h0, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1);

        // reset during SERVICE with irq_in[1] held high
        step(4'h0, 1'b1, 2'd0, 16'h0002, 1'b0, 1'b0);
        step(4'h2, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0);
        step(4'h2, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0);
        chk_out("rst_req", 1'b1, 2'd1, 16'h0044);
        step(4'h2, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0);
        chk("rst_service.status", bus.cfg_rdata, 16'h0009);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_out("rst_mid", 1'b0, 2'd0, 16'h0040);
        rd("rst_mid.status", 2'd2, 16'h0000);
        rd("rst_mid.mask", 2'd0, 16'h0000);
        rd("rst_mid.pending", 2'd1, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step(4'h2, 1'b1, 2'd0, 16'h0002, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(4'h2, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0);
            chk($sformatf("post_rst%0d.pending", k), bus.cfg_rdata, 16'h0000);
            chk($sformatf("post_rst%0d.interrupt", k), {15'd0, bus.interrupt}, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
